// File: rtl/lmc_pkg.sv
// rtl/lmc_pkg.sv - LMC1992 register map, limits, reset defaults and attenuation table
package lmc_pkg;

  localparam logic [2:0] REG_MIXER  = 3'd0;
  localparam logic [2:0] REG_BASS   = 3'd1;
  localparam logic [2:0] REG_TREBLE = 3'd2;
  localparam logic [2:0] REG_MASTER = 3'd3;
  localparam logic [2:0] REG_RVOL   = 3'd4;
  localparam logic [2:0] REG_LVOL   = 3'd5;

  localparam logic [5:0] MAX_MASTER = 6'd40;
  localparam logic [4:0] MAX_CHAN   = 5'd20;
  localparam logic [3:0] MAX_TONE   = 4'd12;

  localparam logic [5:0] RST_MASTER = 6'd40;
  localparam logic [4:0] RST_CHAN   = 5'd20;
  localparam logic [3:0] RST_TONE   = 4'd6;
  localparam logic [1:0] RST_MIXER  = 2'd1;
  localparam logic [7:0] AUDIO_MID  = 8'h80;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DECODE} rx_state_e;

  typedef struct packed {
    logic [5:0] master;
    logic [4:0] lvol;
    logic [4:0] rvol;
    logic [3:0] bass;
    logic [3:0] treble;
    logic [1:0] mixer;
  } lmc_regs_t;

  localparam lmc_regs_t REGS_RESET = '{master: RST_MASTER, lvol: RST_CHAN, rvol: RST_CHAN,
                                       bass: RST_TONE, treble: RST_TONE, mixer: RST_MIXER};

  // Gain per 2 dB step: round(256 * 10^(-k/10)); everything past step 27 rounds to zero.
  function automatic logic [8:0] gain_lookup(input logic [5:0] k);
    logic [8:0] g;
    case (k)
      6'd0:  g = 9'd256;
      6'd1:  g = 9'd203;
      6'd2:  g = 9'd162;
      6'd3:  g = 9'd128;
      6'd4:  g = 9'd102;
      6'd5:  g = 9'd81;
      6'd6:  g = 9'd64;
      6'd7:  g = 9'd51;
      6'd8:  g = 9'd41;
      6'd9:  g = 9'd32;
      6'd10: g = 9'd26;
      6'd11: g = 9'd20;
      6'd12: g = 9'd16;
      6'd13: g = 9'd13;
      6'd14: g = 9'd10;
      6'd15: g = 9'd8;
      6'd16: g = 9'd6;
      6'd17: g = 9'd5;
      6'd18: g = 9'd4;
      6'd19: g = 9'd3;
      6'd20: g = 9'd3;
      6'd21: g = 9'd2;
      6'd22: g = 9'd2;
      6'd23, 6'd24, 6'd25, 6'd26, 6'd27: g = 9'd1;
      default: g = 9'd0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/lmc_microwire_rx_if.sv
// rtl/lmc_microwire_rx_if.sv - microwire link signals between the shifter and the LMC1992
interface lmc_microwire_rx_if;
  logic mw_stb;
  logic mw_clk;
  logic mw_data;
  logic mw_done;

  modport master (output mw_stb, output mw_clk, output mw_data, output mw_done);
  modport slave  (input  mw_stb, input  mw_clk, input  mw_data, input  mw_done);
endinterface

// File: rtl/lmc_atten.sv
// rtl/lmc_atten.sv - one audio channel: step/gain lookup then 2-stage signed multiply
module lmc_atten
  import lmc_pkg::*;
(
  input  logic       clk32,
  input  logic       resb,
  input  logic [7:0] audio_i,
  input  logic [5:0] master_vol_i,
  input  logic [4:0] chan_vol_i,
  output logic [7:0] audio_o
);

  logic [5:0]        step;
  logic signed [7:0] s_q;
  logic [8:0]        g_q;
  logic [7:0]        out_q;
  logic signed [15:0] prod;
  logic [7:0]        prod_unused_lo;
  logic [7:0]        scaled;

  // Volume registers are always clamped, so neither subtraction can underflow.
  assign step = (MAX_MASTER - master_vol_i) + {1'b0, MAX_CHAN - chan_vol_i};

  assign prod = s_q * $signed({1'b0, g_q});
  assign {scaled, prod_unused_lo} = prod;

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      s_q   <= '0;
      g_q   <= 9'd256;
      out_q <= AUDIO_MID;
    end else begin
      s_q   <= $signed({~audio_i[7], audio_i[6:0]});
      g_q   <= gain_lookup(step);
      out_q <= {~scaled[7], scaled[6:0]};
    end
  end

  assign audio_o = out_q;

endmodule

// File: rtl/lmc_microwire_rx.sv
// rtl/lmc_microwire_rx.sv - LMC1992 microwire receiver, register file and stereo attenuator
module lmc_microwire_rx
  import lmc_pkg::*;
#(
  parameter logic [1:0] ADDR_CODE = 2'b10,
  parameter int         CMD_BITS  = 11
) (
  input  logic                      clk32,
  input  logic                      resb,
  lmc_microwire_rx_if.slave         mw,
  input  logic [7:0]                audio_in_left,
  input  logic [7:0]                audio_in_right,
  output logic [7:0]                audio_out_left,
  output logic [7:0]                audio_out_right,
  output logic [5:0]                master_vol,
  output logic [4:0]                left_vol,
  output logic [4:0]                right_vol,
  output logic [3:0]                bass,
  output logic [3:0]                treble,
  output logic [1:0]                mixer,
  output logic                      cmd_err
);

  rx_state_e  state_q, state_d;
  logic       stb_q;
  logic [10:0] sr_q, sr_d;
  logic [3:0] cnt_q, cnt_d;
  lmc_regs_t  regs_q, regs_d;
  logic       cmd_err_q, cmd_err_d;
  logic       bit_valid, bit_end;
  logic [5:0] d;

  // Bits are sampled one clk32 after the strobe so mw_clk/mw_data have settled.
  assign bit_valid = stb_q & mw.mw_clk;
  assign bit_end   = stb_q & ~mw.mw_clk;
  assign d         = sr_q[5:0];

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      state_q   <= ST_IDLE;
      stb_q     <= 1'b0;
      sr_q      <= '0;
      cnt_q     <= '0;
      regs_q    <= REGS_RESET;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stb_q     <= mw.mw_stb;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      regs_q    <= regs_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    regs_d    = regs_q;
    cmd_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bit_valid) begin
          sr_d    = {sr_q[9:0], mw.mw_data};
          cnt_d   = 4'd1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_valid) begin
          sr_d  = {sr_q[9:0], mw.mw_data};
          cnt_d = (cnt_q == 4'd15) ? 4'd15 : cnt_q + 4'd1;
        end
        if (bit_end || mw.mw_done) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        if (cnt_q == 4'(CMD_BITS) && sr_q[10:9] == ADDR_CODE) begin
          case (sr_q[8:6])
            REG_MIXER:  regs_d.mixer  = d[1:0];
            REG_BASS:   regs_d.bass   = (d[3:0] > MAX_TONE) ? MAX_TONE : d[3:0];
            REG_TREBLE: regs_d.treble = (d[3:0] > MAX_TONE) ? MAX_TONE : d[3:0];
            REG_MASTER: regs_d.master = (d > MAX_MASTER) ? MAX_MASTER : d;
            REG_RVOL:   regs_d.rvol   = (d[4:0] > MAX_CHAN) ? MAX_CHAN : d[4:0];
            REG_LVOL:   regs_d.lvol   = (d[4:0] > MAX_CHAN) ? MAX_CHAN : d[4:0];
            default:    regs_d        = regs_q;
          endcase
        end else begin
          cmd_err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  lmc_atten u_atten_left (
    .clk32        (clk32),
    .resb         (resb),
    .audio_i      (audio_in_left),
    .master_vol_i (regs_q.master),
    .chan_vol_i   (regs_q.lvol),
    .audio_o      (audio_out_left)
  );

  lmc_atten u_atten_right (
    .clk32        (clk32),
    .resb         (resb),
    .audio_i      (audio_in_right),
    .master_vol_i (regs_q.master),
    .chan_vol_i   (regs_q.rvol),
    .audio_o      (audio_out_right)
  );

  assign master_vol = regs_q.master;
  assign left_vol   = regs_q.lvol;
  assign right_vol  = regs_q.rvol;
  assign bass       = regs_q.bass;
  assign treble     = regs_q.treble;
  assign mixer      = regs_q.mixer;
  assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_lmc_microwire_rx.sv
// tb/tb_lmc_microwire_rx.sv - directed self-checking bench for lmc_microwire_rx
module tb_lmc_microwire_rx;

  logic       clk32 = 1'b0;
  logic       resb;
  logic [7:0] audio_in_left, audio_in_right;
  logic [7:0] audio_out_left, audio_out_right;
  logic [5:0] master_vol;
  logic [4:0] left_vol, right_vol;
  logic [3:0] bass, treble;
  logic [1:0] mixer;
  logic       cmd_err;

  int total = 0;
  int bad = 0;
  int err_seen = 0;

  lmc_microwire_rx_if mw ();

  lmc_microwire_rx dut (
    .clk32           (clk32),
    .resb            (resb),
    .mw              (mw),
    .audio_in_left   (audio_in_left),
    .audio_in_right  (audio_in_right),
    .audio_out_left  (audio_out_left),
    .audio_out_right (audio_out_right),
    .master_vol      (master_vol),
    .left_vol        (left_vol),
    .right_vol       (right_vol),
    .bass            (bass),
    .treble          (treble),
    .mixer           (mixer),
    .cmd_err         (cmd_err)
  );

  always #5 clk32 = ~clk32;

  always @(negedge clk32) if (cmd_err === 1'b1) err_seen++;

  task automatic send_bit(input logic b, input logic v);
    @(negedge clk32);
    mw.mw_stb = 1'b1; mw.mw_clk = v; mw.mw_data = b;
    @(negedge clk32);
    mw.mw_stb = 1'b0;
    @(negedge clk32);
  endtask

  task automatic send_bits(input logic [15:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(val[i], 1'b1);
  endtask

  task automatic send_cmd(input logic [15:0] val, input int n);
    send_bits(val, n);
    send_bit(1'b0, 1'b0);
    repeat (4) @(negedge clk32);
  endtask

  task automatic pulse_done();
    @(negedge clk32);
    mw.mw_done = 1'b1;
    @(negedge clk32);
    mw.mw_done = 1'b0;
    repeat (4) @(negedge clk32);
  endtask

  task automatic audio_step(input logic [7:0] l, input logic [7:0] r);
    @(negedge clk32);
    audio_in_left = l; audio_in_right = r;
    repeat (2) @(posedge clk32);
    #1;
  endtask

  task automatic test_reset();
    resb = 1'b0;
    mw.mw_stb = 0; mw.mw_clk = 0; mw.mw_data = 0; mw.mw_done = 0;
    audio_in_left = 8'h80; audio_in_right = 8'h80;
    repeat (3) @(negedge clk32);
    total++; if (audio_out_left !== 8'h80) begin bad++; $display("FAIL rst_out_l got=%h exp=80", audio_out_left); end
    resb = 1'b1;
    audio_step(8'hC0, 8'h40);
    total++; if (audio_out_left !== 8'hC0) begin bad++; $display("FAIL unity_l got=%h exp=c0", audio_out_left); end
    total++; if (audio_out_right !== 8'h40) begin bad++; $display("FAIL unity_r got=%h exp=40", audio_out_right); end
    total++;
    if ({master_vol, left_vol, right_vol, bass, treble, mixer, cmd_err} !== {6'd40, 5'd20, 5'd20, 4'd6, 4'd6, 2'd1, 1'b0}) begin
      bad++; $display("FAIL rst_regs got=%0d/%0d/%0d/%0d/%0d/%0d/%0d exp=40/20/20/6/6/1/0",
                      master_vol, left_vol, right_vol, bass, treble, mixer, cmd_err);
    end
  endtask

  task automatic test_master();
    send_cmd(16'h04E5, 11);
    total++; if (master_vol !== 6'd37) begin bad++; $display("FAIL master37 got=%0d exp=37", master_vol); end
    audio_step(8'hC0, 8'h80);
    total++; if (audio_out_left !== 8'hA0) begin bad++; $display("FAIL att_c0 got=%h exp=a0", audio_out_left); end
    audio_step(8'h40, 8'h80);
    total++; if (audio_out_left !== 8'h60) begin bad++; $display("FAIL att_40 got=%h exp=60", audio_out_left); end
  endtask

  task automatic test_clamp();
    send_cmd(16'h057F, 11);
    total++; if (left_vol !== 5'd20) begin bad++; $display("FAIL lvol_clamp got=%0d exp=20", left_vol); end
    send_cmd(16'h044F, 11);
    total++; if (bass !== 4'd12) begin bad++; $display("FAIL bass_clamp got=%0d exp=12", bass); end
    send_cmd(16'h0402, 11);
    total++; if (mixer !== 2'd2) begin bad++; $display("FAIL mixer got=%0d exp=2", mixer); end
    total++; if (err_seen !== 0) begin bad++; $display("FAIL no_err got=%0d exp=0", err_seen); end
  endtask

  task automatic test_errors();
    send_cmd(16'h02C0, 11);
    total++; if (err_seen !== 1) begin bad++; $display("FAIL err_addr got=%0d exp=1", err_seen); end
    total++; if (master_vol !== 6'd37) begin bad++; $display("FAIL addr_nowrite got=%0d exp=37", master_vol); end
    send_cmd(16'h04C0, 12);
    total++; if (err_seen !== 2) begin bad++; $display("FAIL err_long got=%0d exp=2", err_seen); end
    total++; if (master_vol !== 6'd37) begin bad++; $display("FAIL long_nowrite got=%0d exp=37", master_vol); end
    send_bits(16'h0260, 10);
    pulse_done();
    total++; if (err_seen !== 3) begin bad++; $display("FAIL err_short got=%0d exp=3", err_seen); end
    total++; if (master_vol !== 6'd37) begin bad++; $display("FAIL short_nowrite got=%0d exp=37", master_vol); end
    pulse_done();
    total++; if (err_seen !== 3) begin bad++; $display("FAIL done_idle got=%0d exp=3", err_seen); end
  endtask

  task automatic test_mute_and_step3();
    send_cmd(16'h04C0, 11);
    send_cmd(16'h0500, 11);
    total++; if (right_vol !== 5'd0) begin bad++; $display("FAIL rvol0 got=%0d exp=0", right_vol); end
    audio_step(8'h80, 8'hFF);
    total++; if (audio_out_right !== 8'h80) begin bad++; $display("FAIL mute_ff got=%h exp=80", audio_out_right); end
    audio_step(8'h80, 8'h00);
    total++; if (audio_out_right !== 8'h80) begin bad++; $display("FAIL mute_00 got=%h exp=80", audio_out_right); end
    send_cmd(16'h04E8, 11);
    send_cmd(16'h0511, 11);
    total++; if (right_vol !== 5'd17) begin bad++; $display("FAIL rvol17 got=%0d exp=17", right_vol); end
    audio_step(8'hC0, 8'hC0);
    total++; if (audio_out_right !== 8'hA0) begin bad++; $display("FAIL k3_r got=%h exp=a0", audio_out_right); end
    total++; if (audio_out_left !== 8'hC0) begin bad++; $display("FAIL k0_l got=%h exp=c0", audio_out_left); end
  endtask

  task automatic test_reset_mid_transfer();
    int err_before;
    err_before = err_seen;
    send_bits(16'h0025, 6);
    @(negedge clk32);
    resb = 1'b0;
    #1;
    total++; if (audio_out_left !== 8'h80) begin bad++; $display("FAIL async_out got=%h exp=80", audio_out_left); end
    repeat (3) @(negedge clk32);
    total++;
    if ({bass, right_vol, mixer} !== {4'd6, 5'd20, 2'd1}) begin
      bad++; $display("FAIL mid_rst_regs got=%0d/%0d/%0d exp=6/20/1", bass, right_vol, mixer);
    end
    resb = 1'b1;
    send_cmd(16'h0484, 11);
    total++; if (treble !== 4'd4) begin bad++; $display("FAIL treble4 got=%0d exp=4", treble); end
    total++; if (master_vol !== 6'd40) begin bad++; $display("FAIL master_kept got=%0d exp=40", master_vol); end
    total++; if (err_seen !== err_before) begin bad++; $display("FAIL abort_err got=%0d exp=%0d", err_seen, err_before); end
  endtask

  initial begin
    test_reset();
    test_master();
    test_clamp();
    test_errors();
    test_mute_and_step3();
    test_reset_mid_transfer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lmc_microwire_rx.md
Name: lmc_microwire_rx

Overview:
- Receiving end of the STE microwire link: the LMC1992 volume/tone controller the sound block talks to.
- Deserialises the mask-qualified microwire bit stream (mw_clk/mw_data/mw_done plus a per-bit strobe) into the LMC1992 register set.
- Applies master + per-channel attenuation to the 8-bit offset-binary DMA audio.
- Sits between the shifter's DMA sound outputs and the board audio DAC path.

Parameters:
- ADDR_CODE, 2'b10, device address expected in the first two received bits.
- CMD_BITS, 11, exact command length (2 address + 3 register select + 6 data).

Ports:
- clk32  in  1  system clock (32 MHz).
- resb  in  1  reset, asynchronous, active-low.
- mw_stb  in  1  one-cycle pulse in the same cycle mw_clk/mw_data change (per bit period).
- mw_clk  in  1  mask bit: 1 = current bit is valid.
- mw_data  in  1  serial data, MSB first.
- mw_done  in  1  one-cycle end-of-transfer pulse.
- audio_in_left  in  8  unsigned offset-binary sample (128 = silence).
- audio_in_right  in  8  as above.
- audio_out_left  out  8  attenuated sample, offset-binary.
- audio_out_right  out  8  as above.
- master_vol  out  6  0..40 (40 = 0 dB, 2 dB steps).
- left_vol  out  5  0..20 (20 = 0 dB).
- right_vol  out  5  0..20.
- bass  out  4  0..12 (6 = flat).
- treble  out  4  0..12 (6 = flat).
- mixer  out  2  input mix select.
- cmd_err  out  1  one-cycle pulse on a rejected command.

Behaviour:
- Reset values: master_vol=40, left_vol=20, right_vol=20, bass=6, treble=6, mixer=1, audio_out_*=8'h80, cmd_err=0. Receive state is cleared to IDLE with bit count 0.
- Input sampling: mw_stb is registered; mw_clk/mw_data are captured on the cycle after mw_stb (sample point one clk32 after the change).
- States:
  - IDLE: on a sample with mw_clk=1, shift the bit in, set cnt=1, go to SHIFT.
  - SHIFT: each sample with mw_clk=1 shifts left into an 11-bit register (last 11 bits retained); cnt increments, saturating at 15.
  - SHIFT ends on either a sample with mw_clk=0 or mw_done. Either ending goes to DECODE.
  - DECODE (1 cycle): accept iff cnt==11 and sr[10:9]==ADDR_CODE. Otherwise pulse cmd_err and write nothing. Return to IDLE.
- Legal commands:
  - cnt>11 is rejected (cmd_err); cnt<11 is rejected.
  - mw_done in IDLE is ignored.
  - mw_done coinciding with a valid-bit sample: the bit is shifted first, then DECODE follows.
- Register select sr[8:6], data d=sr[5:0]:
  - 000 mixer=d[1:0].
  - 001 bass=min(d[3:0],12).
  - 010 treble=min(d[3:0],12).
  - 011 master_vol=min(d,40).
  - 100 right_vol=min(d[4:0],20).
  - 101 left_vol=min(d[4:0],20).
  - 11x: accepted, no register write, no error.
- Register outputs update the cycle after DECODE.
- Audio pipeline runs every cycle, latency 2 clk32.
  - Stage 1: s = {~in[7], in[6:0]} as signed 8-bit. Step k = (40-master_vol)+(20-chan_vol), range 0..60. g = GAIN_TAB[k], 9-bit unsigned.
  - Stage 2: p = s*g as 17-bit signed; out = (p >>> 8)[7:0] with MSB inverted (back to offset-binary).
  - No saturation is needed because g≤256 means |out|≤|s|.
- Volume register changes take effect in the next stage-1 computation. No glitch smoothing.
- Reset asserted mid-transfer: partial command discarded, registers return to reset values, audio outputs go to 8'h80 immediately (asynchronous).

Decomposition:
- Package lmc_pkg:
  - register-select constants REG_MIXER..REG_LVOL.
  - limits MAX_MASTER=40, MAX_CHAN=20, MAX_TONE=12.
  - reset defaults.
  - GAIN_TAB[0:60], entry k = round(256*10^(-k/10)), e.g. k=0→256, 1→203, 3→128, 10→26.
- Sub-module lmc_atten (one channel: step computation, table lookup, 2-stage multiply) is instantiated twice.

Test Plan:
- Reset, then audio_in_left=8'hC0 → audio_out_left=8'hC0 two cycles later; register outputs equal their defaults.
- Send 11 valid bits 10_011_100101 (master=37) → master_vol=37. Then in=8'hC0 → out=8'hA0; in=8'h40 → out=8'h60.
- Send 10_101_111111 (left=63) → left_vol clamps to 20. Send 10_001_001111 → bass=12.
- Send 01_011_000000 (wrong address) → cmd_err pulse, master_vol unchanged. Send 12 valid bits → cmd_err pulse. Send 10 valid bits then mw_done → cmd_err pulse.
- Send master=0 and right=0 (k=60) → audio_out_right=8'h80 for any input. Set right=17 with master=40 (k=3) → in 8'hC0 gives out 8'hA0.
- Assert resb low after 6 bits of a transfer, release, then send a full valid command → only the new command is applied; no cmd_err for the aborted transfer.
